// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Definitions shared by the CNN layer stages: the convolution stage and the
// average-pool stage downstream of it.
//   DATA_W        feature-map / weight word width (Q16.16)
//   FRAC_BITS     number of fraction bits in a data word
//   ACC_W         accumulator width used by the MAC
//   layer_state_t sequencing states common to the layer stages
//   sat32()       clamps an (ACC_W+1)-bit signed value to the 32-bit range
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int DATA_W    = 32;
  localparam int FRAC_BITS = 16;
  localparam int ACC_W     = 48;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    WAIT,
    WRITE,
    DONE
  } layer_state_t;

  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  // Clamp to [0x80000000, 0x7FFFFFFF]; in-range values pass through unchanged.
  function automatic logic signed [DATA_W-1:0] sat32(input logic signed [ACC_W:0] x);
    if (x > SAT_MAX)
      return {1'b0, {(DATA_W - 1){1'b1}}};
    else if (x < SAT_MIN)
      return {1'b1, {(DATA_W - 1){1'b0}}};
    else
      return x[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/conv_mac.sv
// -----------------------------------------------------------------------------
// conv_mac
// Two-stage pipelined fixed-point multiply-accumulate.
//   Stage 1 registers (a*b) >>> FRAC_BITS (arithmetic, truncating toward -inf).
//   Stage 2 adds the registered product into the accumulator.
// A product presented with en=1 is visible in acc two edges later.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   clr  synchronous clear of both pipeline stages
//   en   a/b carry a valid tap this cycle
//   a,b  signed Q16.16 operands
//   acc  signed ACC_W-bit running sum
// -----------------------------------------------------------------------------
module conv_mac
  import cnn_pkg::*;
#(
  parameter int FRAC_BITS = cnn_pkg::FRAC_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod_full;
  logic signed [ACC_W-1:0]    prod_q;
  logic                       prod_vld_q;

  assign prod_full = a * b;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would let stage 2 see this
  // cycle's product instead of last cycle's.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc        <= '0;
    end else begin
      prod_q     <= ACC_W'(prod_full >>> FRAC_BITS);
      prod_vld_q <= en;
      if (prod_vld_q)
        acc <= acc + prod_q;
    end
  end

endmodule

// File: rtl/conv_layer.sv
// -----------------------------------------------------------------------------
// conv_layer
// Single-channel 3x3 valid convolution of an 8x8 Q16.16 map plus bias, with
// saturation and optional ReLU, producing the 6x6 map the pool stage reads.
// One output pixel every 13 cycles: CLEAR(1) + FEED(9) + WAIT(2) + WRITE(1).
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (aborts a pass)
//   start      begin a pass; only looked at in IDLE
//   input_fm   input map, row-major, captured at the accepting edge
//   kernel     3x3 weights, row-major, captured at the accepting edge
//   bias       added once per output, captured at the accepting edge
//   busy       high from the accepting edge until the DONE state
//   done       output_fm valid; held until the next accepted start
//   output_fm  result map, row-major
// -----------------------------------------------------------------------------
module conv_layer
  import cnn_pkg::*;
#(
  parameter int FM_IN_W   = 8,
  parameter int FM_IN_H   = 8,
  parameter int K         = 3,
  parameter int FRAC_BITS = 16,
  parameter int RELU_EN   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] input_fm  [FM_IN_W*FM_IN_H],
  input  logic signed [DATA_W-1:0] kernel    [K*K],
  input  logic signed [DATA_W-1:0] bias,
  output logic                     busy,
  output logic                     done,
  output logic signed [DATA_W-1:0] output_fm [(FM_IN_W-K+1)*(FM_IN_H-K+1)]
);

  localparam int FM_OUT_W = FM_IN_W - K + 1;
  localparam int FM_OUT_H = FM_IN_H - K + 1;
  localparam int N_IN     = FM_IN_W * FM_IN_H;
  localparam int N_OUT    = FM_OUT_W * FM_OUT_H;
  localparam int N_TAP    = K * K;

  localparam int IN_AW  = $clog2(N_IN);
  localparam int OUT_AW = $clog2(N_OUT);
  localparam int TAP_W  = $clog2(N_TAP);
  localparam int KC_W   = $clog2(K);
  localparam int POS_W  = $clog2(FM_IN_W > FM_IN_H ? FM_IN_W : FM_IN_H);

  localparam logic [POS_W-1:0] LAST_COL = POS_W'(FM_OUT_W - 1);
  localparam logic [POS_W-1:0] LAST_ROW = POS_W'(FM_OUT_H - 1);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAP - 1);
  localparam logic [KC_W-1:0]  LAST_KC  = KC_W'(K - 1);

  layer_state_t state;

  logic [POS_W-1:0] row, col;
  logic [TAP_W-1:0] tap;
  logic [KC_W-1:0]  tap_r, tap_c;      // tap expressed as kernel row/column
  logic             drain_cnt;

  logic signed [DATA_W-1:0] in_q  [N_IN];
  logic signed [DATA_W-1:0] ker_q [N_TAP];
  logic signed [DATA_W-1:0] bias_q;

  logic [IN_AW-1:0]         pix_addr;
  logic [OUT_AW-1:0]        out_addr;
  logic signed [DATA_W-1:0] mac_a, mac_b;
  logic                     mac_clr, mac_en;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    sum;
  logic signed [DATA_W-1:0] sat_val, wr_val;

  // Operand capture lets the caller change its inputs right after start.
  // NOTE: these capture registers carry no reset: they are only read after
  // an accepted start has loaded them, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && start) begin
      in_q   <= input_fm;
      ker_q  <= kernel;
      bias_q <= bias;
    end
  end

  assign pix_addr = IN_AW'((int'(row) + int'(tap_r)) * FM_IN_W + int'(col) + int'(tap_c));
  assign out_addr = OUT_AW'(int'(row) * FM_OUT_W + int'(col));
  assign mac_a    = in_q[pix_addr];
  assign mac_b    = ker_q[tap];
  assign mac_clr  = (state == CLEAR);
  assign mac_en   = (state == FEED);

  conv_mac #(
    .FRAC_BITS(FRAC_BITS)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (mac_a),
    .b   (mac_b),
    .acc (acc)
  );

  // Bias added at full accumulator width plus a guard bit, then saturated,
  // then ReLU on the saturated value.
  // NOTE: every combinational output is assigned on all paths (default
  // first), so no latch can be inferred.
  always_comb begin
    sum     = {acc[ACC_W-1], acc} + {{(ACC_W - DATA_W + 1){bias_q[DATA_W-1]}}, bias_q};
    sat_val = sat32(sum);
    wr_val  = sat_val;
    if (RELU_EN != 0 && sat_val[DATA_W-1])
      wr_val = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      row       <= '0;
      col       <= '0;
      tap       <= '0;
      tap_r     <= '0;
      tap_c     <= '0;
      drain_cnt <= 1'b0;
      for (int i = 0; i < N_OUT; i++)
        output_fm[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            done  <= 1'b0;
            row   <= '0;
            col   <= '0;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          tap       <= '0;
          tap_r     <= '0;
          tap_c     <= '0;
          drain_cnt <= 1'b0;
          state     <= FEED;
        end
        FEED: begin
          if (tap == LAST_TAP) begin
            state <= WAIT;
          end else begin
            tap <= tap + 1'b1;
            if (tap_c == LAST_KC) begin
              tap_c <= '0;
              tap_r <= tap_r + 1'b1;
            end else begin
              tap_c <= tap_c + 1'b1;
            end
          end
        end
        WAIT: begin
          drain_cnt <= 1'b1;
          if (drain_cnt)
            state <= WRITE;
        end
        WRITE: begin
          output_fm[out_addr] <= wr_val;
          if (col != LAST_COL) begin
            col   <= col + 1'b1;
            state <= CLEAR;
          end else if (row != LAST_ROW) begin
            col   <= '0;
            row   <= row + 1'b1;
            state <= CLEAR;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer.sv
// -----------------------------------------------------------------------------
// tb_conv_layer
// Self-checking bench for conv_layer. Two instances share all inputs: one with
// ReLU enabled, one without. Expected maps come from a direct nested-loop
// evaluation of the convolution arithmetic.
// -----------------------------------------------------------------------------
module tb_conv_layer;
  import cnn_pkg::*;

  localparam int DONE_EDGE = 469;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic signed [31:0] input_fm [64];
  logic signed [31:0] kernel   [9];
  logic signed [31:0] bias;
  logic               busy_r, done_r, busy_l, done_l;
  logic signed [31:0] out_r [36];
  logic signed [31:0] out_l [36];

  always #5 clk = ~clk;

  conv_layer #(.RELU_EN(1)) dut_relu (
    .clk(clk), .rst(rst), .start(start), .input_fm(input_fm), .kernel(kernel),
    .bias(bias), .busy(busy_r), .done(done_r), .output_fm(out_r)
  );

  conv_layer #(.RELU_EN(0)) dut_lin (
    .clk(clk), .rst(rst), .start(start), .input_fm(input_fm), .kernel(kernel),
    .bias(bias), .busy(busy_l), .done(done_l), .output_fm(out_l)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus for the current pass and the expected maps it should produce.
  logic signed [31:0] pix [64];
  logic signed [31:0] ker [9];
  logic signed [31:0] bia;
  logic signed [31:0] exp_r [36];
  logic signed [31:0] exp_l [36];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Direct evaluation: sum of truncated Q16.16 products, 48-bit wrap, bias,
  // clamp to 32 bits, then optional ReLU.
  function automatic logic signed [31:0] model_px(input int r, input int c, input bit relu);
    longint acc = 0;
    logic signed [31:0] res;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += (longint'(pix[(r + i) * 8 + c + j]) * longint'(ker[i * 3 + j])) >>> 16;
    acc = (acc <<< 16) >>> 16;
    acc += longint'(bia);
    if (acc > 64'sd2147483647)       res = 32'h7FFF_FFFF;
    else if (acc < -64'sd2147483648) res = 32'h8000_0000;
    else                             res = acc[31:0];
    if (relu && res < 0) res = 0;
    return res;
  endfunction

  task automatic build_model();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        exp_r[r * 6 + c] = model_px(r, c, 1'b1);
        exp_l[r * 6 + c] = model_px(r, c, 1'b0);
      end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 36; i++) begin
      check($sformatf("%s relu out[%0d]", tag, i), out_r[i], exp_r[i]);
      check($sformatf("%s lin out[%0d]", tag, i), out_l[i], exp_l[i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    int nz = 0;
    for (int i = 0; i < 36; i++)
      if (out_r[i] !== 32'sd0 || out_l[i] !== 32'sd0) nz++;
    check({tag, " nonzero outputs"}, nz, 0);
  endtask

  // One pass: accept, scramble the live inputs, walk the edges checking
  // busy/done timing. abort_at > 0 asserts rst sampled at that edge instead.
  // glitch pulses start at edges 50 and 200 while busy.
  task automatic run_pass(input string tag, input int abort_at, input bit glitch);
    int done_edge = -1;
    int bad = 0;
    logic signed [31:0] old35_r, old35_l;
    old35_r = out_r[35];
    old35_l = out_l[35];
    input_fm = pix;
    kernel   = ker;
    bias     = bia;
    build_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy after accept"}, {busy_r, busy_l}, 2'b11);
    check({tag, " done after accept"}, {done_r, done_l}, 2'b00);
    for (int i = 0; i < 64; i++) input_fm[i] = $urandom;
    for (int i = 0; i < 9; i++)  kernel[i]   = $urandom;
    bias = $urandom;
    for (int k = 1; k <= DONE_EDGE + 10 && done_edge < 0; k++) begin
      start = glitch && (k == 50 || k == 200);
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check({tag, " busy after abort"}, {busy_r, busy_l}, 2'b00);
        check({tag, " done after abort"}, {done_r, done_l}, 2'b00);
        check_all_zero({tag, " abort"});
        return;
      end
      tick();
      start = 1'b0;
      if (glitch && k == 200) begin
        check({tag, " relu out[35] held"}, out_r[35], old35_r);
        check({tag, " lin out[35] held"}, out_l[35], old35_l);
      end
      if (busy_r !== (k < DONE_EDGE) || busy_l !== busy_r || done_l !== done_r) bad++;
      if (done_r === 1'b1) done_edge = k;
    end
    check({tag, " done edge"}, done_edge, DONE_EDGE);
    check({tag, " busy/done timing errors"}, bad, 0);
    check_outputs(tag);
  endtask

  task automatic fill(input logic signed [31:0] p, input logic signed [31:0] w,
                      input logic signed [31:0] b);
    for (int i = 0; i < 64; i++) pix[i] = p;
    for (int i = 0; i < 9; i++)  ker[i] = w;
    bia = b;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bias  = '0;
    for (int i = 0; i < 64; i++) input_fm[i] = '0;
    for (int i = 0; i < 9; i++)  kernel[i]   = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset busy", {busy_r, busy_l}, 2'b00);
    check("reset done", {done_r, done_l}, 2'b00);
    check_all_zero("reset");

    // start coinciding with rst is ignored
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("start with rst busy", {busy_r, busy_l}, 2'b00);
    tick();
    check("start with rst still idle", {busy_r, busy_l}, 2'b00);

    // all-ones map and kernel
    fill(32'sh0001_0000, 32'sh0001_0000, 32'sd0);
    run_pass("ones", 0, 1'b0);
    check("ones out[17] value", out_r[17], 32'sh0009_0000);

    // done holds while idle
    repeat (3) tick();
    check("done held in idle", {done_r, done_l, busy_r}, 3'b110);

    // ramp with centre tap and half bias (starts back-to-back after idle gap)
    for (int i = 0; i < 64; i++) pix[i] = i <<< 16;
    for (int i = 0; i < 9; i++)  ker[i] = '0;
    ker[4] = 32'sh0001_0000;
    bia    = 32'sh0000_8000;
    run_pass("ramp", 0, 1'b0);
    check("ramp out[0] value", out_l[0], 32'sh0009_8000);

    // negative kernel: back-to-back start right after DONE
    fill(32'sh0001_0000, -32'sh0001_0000, 32'sd0);
    run_pass("negkern", 0, 1'b0);
    check("negkern lin value", out_l[7], 32'shFFF7_0000);

    // positive and negative saturation
    fill(32'sh7FFF_0000, 32'sh0001_0000, 32'sd0);
    run_pass("satpos", 0, 1'b0);
    fill(32'sh7FFF_0000, -32'sh0001_0000, 32'sd0);
    run_pass("satneg", 0, 1'b0);
    check("satneg lin value", out_l[20], 32'sh8000_0000);

    // abort at edge 100, then a fresh random pass
    for (int i = 0; i < 64; i++) pix[i] = $signed(32'($urandom_range(0, 32'h0040_0000))) - 32'sh0020_0000;
    for (int i = 0; i < 9; i++)  ker[i] = $signed(32'($urandom_range(0, 32'h0004_0000))) - 32'sh0002_0000;
    bia = $signed(32'($urandom_range(0, 32'h0010_0000))) - 32'sh0008_0000;
    run_pass("abort", 100, 1'b0);
    run_pass("rand_mod", 0, 1'b0);

    // full-range random operands with stray start pulses mid-pass
    for (int i = 0; i < 64; i++) pix[i] = $urandom;
    for (int i = 0; i < 9; i++)  ker[i] = $urandom;
    bia = $urandom;
    run_pass("rand_full_glitch", 0, 1'b1);

    // another moderate random pass, immediately back-to-back
    for (int i = 0; i < 64; i++) pix[i] = $signed(32'($urandom_range(0, 32'h0100_0000))) - 32'sh0080_0000;
    for (int i = 0; i < 9; i++)  ker[i] = $signed(32'($urandom_range(0, 32'h0002_0000))) - 32'sh0001_0000;
    bia = $urandom;
    run_pass("rand_b2b", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
